// File: rtl/lepton_pkg.sv
// Shared constants and types for the Lepton VoSPI receive path.
package lepton_pkg;

    localparam int VOSPI_BYTES     = 164;
    localparam int VOSPI_WORDS     = 41;
    localparam int PIXELS_PER_LINE = 80;
    localparam int LINES_PER_FRAME = 60;
    localparam logic [3:0] DISCARD_NIBBLE = 4'hF;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PAY  = 2'd1,
        DROP = 2'd2
    } parser_state_t;

endpackage

// File: rtl/vospi_word_unpack.sv
// Holds one 32-bit payload word and hands it out as two big-endian 16-bit pixels.
module vospi_word_unpack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        pix_ready_i,
    output logic        in_ready_o,
    output logic        pix_valid_o,
    output logic        pix_accept_o,
    output logic [15:0] pix_data_o
);

    logic [31:0] hold_q, hold_d;
    logic        hold_v_q, hold_v_d;
    logic        half_q, half_d;

    assign pix_valid_o  = hold_v_q;
    assign pix_accept_o = hold_v_q && pix_ready_i;
    // A new word may enter in the same cycle its predecessor's second pixel leaves.
    assign in_ready_o   = !hold_v_q || (half_q && pix_ready_i);
    assign pix_data_o   = half_q ? {hold_q[23:16], hold_q[31:24]}
                                 : {hold_q[7:0],   hold_q[15:8]};

    always_comb begin
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        half_d   = half_q;
        if (pix_accept_o) begin
            if (half_q) begin
                hold_v_d = 1'b0;
                half_d   = 1'b0;
            end else begin
                half_d   = 1'b1;
            end
        end
        if (load_i) begin
            hold_d   = word_i;
            hold_v_d = 1'b1;
            half_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            half_q   <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            half_q   <= half_d;
        end
    end

endmodule

// File: rtl/vospi_packet_parser.sv
// VoSPI packet parser: header decode, discard/sequence handling, 32->16 pixel stream with SOF/EOL.
module vospi_packet_parser
    import lepton_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int LINES          = LINES_PER_FRAME,
    parameter int WORDS_PER_PKT  = VOSPI_WORDS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [15:0]               m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tuser,
    output logic                      m_axis_tlast,
    output logic                      frame_done,
    output logic                      seq_error,
    output logic [5:0]                line_num
);

    localparam logic [5:0] PAY_WORDS = 6'(WORDS_PER_PKT - 1);
    localparam logic [5:0] LAST_PAY  = 6'(WORDS_PER_PKT - 2);
    localparam logic [6:0] LAST_PIX  = 7'(PIXELS_PER_LINE - 1);
    localparam logic [5:0] LAST_LINE = 6'(LINES - 1);

    parser_state_t state_q, state_d;
    logic [5:0]    word_cnt_q, word_cnt_d;
    logic [6:0]    pix_idx_q, pix_idx_d;
    logic [5:0]    line_q, line_d;
    logic          frame_done_q, frame_done_d;
    logic          seq_error_q, seq_error_d;

    logic          load;
    logic          unpack_ready;
    logic          pix_valid;
    logic          pix_accept;
    logic          disc;
    logic [11:0]   pkt;

    assign disc = (s_axis_tdata[3:0] == DISCARD_NIBBLE);
    assign pkt  = {s_axis_tdata[3:0], s_axis_tdata[15:8]};

    vospi_word_unpack u_unpack (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load),
        .word_i       (s_axis_tdata),
        .pix_ready_i  (m_axis_tready),
        .in_ready_o   (unpack_ready),
        .pix_valid_o  (pix_valid),
        .pix_accept_o (pix_accept),
        .pix_data_o   (m_axis_tdata)
    );

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        pix_idx_d     = pix_idx_q;
        line_d        = line_q;
        frame_done_d  = 1'b0;
        seq_error_d   = 1'b0;
        s_axis_tready = 1'b0;
        load          = 1'b0;
        case (state_q)
            HDR: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    word_cnt_d = '0;
                    pix_idx_d  = '0;
                    if (disc) begin
                        state_d = DROP;
                    end else if (pkt == 12'(line_q)) begin
                        state_d = PAY;
                    end else if (pkt == 12'd0) begin
                        state_d     = PAY;
                        line_d      = '0;
                        seq_error_d = 1'b1;
                    end else begin
                        state_d     = DROP;
                        line_d      = '0;
                        seq_error_d = 1'b1;
                    end
                end
            end
            PAY: begin
                // Stop taking beats once the whole payload is in, so the next header is never absorbed.
                s_axis_tready = unpack_ready && (word_cnt_q != PAY_WORDS);
                load          = s_axis_tvalid && s_axis_tready;
                if (load) begin
                    word_cnt_d = word_cnt_q + 6'd1;
                end
                if (pix_accept) begin
                    if (pix_idx_q == LAST_PIX) begin
                        pix_idx_d = '0;
                        state_d   = HDR;
                        if (line_q == LAST_LINE) begin
                            line_d       = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            line_d = line_q + 6'd1;
                        end
                    end else begin
                        pix_idx_d = pix_idx_q + 7'd1;
                    end
                end
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    word_cnt_d = word_cnt_q + 6'd1;
                    if (word_cnt_q == LAST_PAY) begin
                        state_d = HDR;
                    end
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HDR;
            word_cnt_q   <= '0;
            pix_idx_q    <= '0;
            line_q       <= '0;
            frame_done_q <= 1'b0;
            seq_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            pix_idx_q    <= pix_idx_d;
            line_q       <= line_d;
            frame_done_q <= frame_done_d;
            seq_error_q  <= seq_error_d;
        end
    end

    assign m_axis_tvalid = pix_valid;
    assign m_axis_tuser  = pix_valid && (line_q == 6'd0) && (pix_idx_q == 7'd0);
    assign m_axis_tlast  = pix_valid && (pix_idx_q == LAST_PIX);
    assign frame_done    = frame_done_q;
    assign seq_error     = seq_error_q;
    assign line_num      = line_q;

endmodule

// File: tb/tb_vospi_packet_parser.sv
// Randomized bench for vospi_packet_parser against a packet-level reference model.
module tb_vospi_packet_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tuser;
    logic        m_tlast;
    logic        frame_done;
    logic        seq_error;
    logic [5:0]  line_num;

    vospi_packet_parser dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .frame_done    (frame_done),
        .seq_error     (seq_error),
        .line_num      (line_num)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        u;
        logic        l;
    } pix_t;

    pix_t        exp_q[$];
    logic [31:0] cur_pay[40];
    int checks = 0, errors = 0;
    int exp_line = 0, exp_fd = 0, exp_se = 0;
    int got_fd = 0, got_se = 0, got_pix = 0, got_user = 0, got_last = 0;
    bit rand_ready = 1'b0, gaps = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [15:0] pix_of(input logic [31:0] w, input bit hi);
        return hi ? {w[23:16], w[31:24]} : {w[7:0], w[15:8]};
    endfunction

    // Reference: what a whole packet must produce, decided from its header and the expected line.
    task automatic model_packet(input logic [31:0] hdr);
        bit          emit;
        logic [11:0] pkt;
        pix_t        p;
        emit = 1'b0;
        pkt  = {hdr[3:0], hdr[15:8]};
        if (hdr[3:0] != 4'hF) begin
            if (pkt == 12'(exp_line)) begin
                emit = 1'b1;
            end else if (pkt == 12'd0) begin
                exp_se++;
                exp_line = 0;
                emit = 1'b1;
            end else begin
                exp_se++;
                exp_line = 0;
            end
        end
        if (emit) begin
            for (int n = 0; n < 80; n++) begin
                p.d = pix_of(cur_pay[n / 2], (n % 2) == 1);
                p.u = (exp_line == 0) && (n == 0);
                p.l = (n == 79);
                exp_q.push_back(p);
            end
            if (exp_line == 59) begin
                exp_line = 0;
                exp_fd++;
            end else begin
                exp_line++;
            end
        end
    endtask

    always @(posedge clk) begin
        #2 m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic        prev_stall = 1'b0;
    logic [17:0] prev_out = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_stable", {14'd0, m_tvalid, m_tdata, m_tuser, m_tlast},
                      {14'd0, 1'b1, prev_out});
            end
            if (m_tvalid && m_tready) begin
                got_pix++;
                if (m_tuser) got_user++;
                if (m_tlast) got_last++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 32'(m_tdata), 32'hDEAD0000);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    check("pix_data", 32'(m_tdata), 32'(e.d));
                    check("pix_tuser", 32'(m_tuser), 32'(e.u));
                    check("pix_tlast", 32'(m_tlast), 32'(e.l));
                end
            end
            if (m_tvalid && !m_tready) begin
                check("in_ready_while_stalled", 32'(s_tready), 32'd0);
            end
            if (frame_done) got_fd++;
            if (seq_error) got_se++;
            prev_stall = m_tvalid && !m_tready;
            prev_out   = {m_tdata, m_tuser, m_tlast};
        end
    end

    task automatic send_beat(input logic [31:0] w);
        int n;
        bit acc;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            @(negedge clk);
            s_tvalid = 1'b0;
        end
        @(negedge clk);
        s_tdata  = w;
        s_tvalid = 1'b1;
        n = 0;
        forever begin
            #1 acc = s_tready;
            @(posedge clk);
            if (acc) break;
            n++;
            if (n > 2000) begin
                $display("FAIL beat_timeout: s_axis_tready stuck low");
                $fatal(1, "input handshake timeout");
            end
            @(negedge clk);
        end
    endtask

    task automatic send_packet(input int id, input bit disc, input bit rnd, input int nwords);
        logic [31:0] hdr;
        for (int k = 0; k < 40; k++) cur_pay[k] = rnd ? $urandom : (32'hAABB0000 + 32'(k));
        if (disc) hdr = {16'($urandom), 8'($urandom), 8'h0F};
        else      hdr = {16'($urandom), 8'(id), 4'($urandom_range(0, 14)), 4'(id >> 8)};
        model_packet(hdr);
        send_beat(hdr);
        for (int k = 0; k < nwords; k++) send_beat(cur_pay[k]);
    endtask

    task automatic finish_input();
        @(negedge clk);
        s_tvalid = 1'b0;
    endtask

    task automatic drain_and_check(input string tag);
        int n;
        finish_input();
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_line_num"}, 32'(line_num), 32'(exp_line));
        check({tag, "_seq_errors"}, 32'(got_se), 32'(exp_se));
        check({tag, "_frame_dones"}, 32'(got_fd), 32'(exp_fd));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd1);
        check("rst_line_num", 32'(line_num), 32'd0);
        check("rst_flags", {28'd0, m_tuser, m_tlast, frame_done, seq_error}, 32'd0);
        rst_n = 1'b1;

        check("model_pix_lo", 32'(pix_of(32'hAABB0005, 1'b0)), 32'h0500);
        check("model_pix_hi", 32'(pix_of(32'hAABB0005, 1'b1)), 32'hBBAA);

        // Full frame, constant pattern, with a discard packet after line 10.
        for (int l = 0; l < 60; l++) begin
            send_packet(l, 1'b0, 1'b0, 40);
            if (l == 10) begin
                send_packet(0, 1'b1, 1'b0, 40);
                drain_and_check("discard");
                check("discard_line_lit", 32'(line_num), 32'd11);
            end
        end
        drain_and_check("frame1");
        check("frame1_pixels_lit", 32'(got_pix), 32'd4800);
        check("frame1_tuser_lit", 32'(got_user), 32'd1);
        check("frame1_tlast_lit", 32'(got_last), 32'd60);
        check("frame1_done_lit", 32'(got_fd), 32'd1);
        check("frame1_seqerr_lit", 32'(got_se), 32'd0);

        // Skipped line: 0..4 then 6, then resync on 0.
        for (int l = 0; l < 5; l++) send_packet(l, 1'b0, 1'b1, 40);
        send_packet(6, 1'b0, 1'b1, 40);
        drain_and_check("skip");
        check("skip_line_lit", 32'(line_num), 32'd0);
        check("skip_seqerr_lit", 32'(got_se), 32'd1);
        send_packet(0, 1'b0, 1'b1, 40);
        drain_and_check("resync");

        // Backpressured frame with input gaps.
        rand_ready = 1'b1;
        gaps       = 1'b1;
        for (int l = 1; l < 60; l++) send_packet(l, 1'b0, 1'b1, 40);
        drain_and_check("bp_frame");

        // Packet 0 arriving at line 30 restarts the frame.
        for (int l = 0; l < 30; l++) send_packet(l, 1'b0, 1'b1, 40);
        send_packet(0, 1'b0, 1'b1, 40);
        drain_and_check("restart");
        check("restart_line_lit", 32'(line_num), 32'd1);

        // Mixed random headers.
        for (int i = 0; i < 30; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 7)       send_packet(exp_line, 1'b0, 1'b1, 40);
            else if (r == 7) send_packet(0, 1'b1, 1'b1, 40);
            else if (r == 8) send_packet($urandom_range(0, 63), 1'b0, 1'b1, 40);
            else             send_packet($urandom_range(60, 4095), 1'b0, 1'b1, 40);
        end
        drain_and_check("random");

        // Reset in the middle of a payload.
        rand_ready = 1'b0;
        gaps       = 1'b0;
        send_packet((exp_line == 59) ? 0 : exp_line, 1'b0, 1'b1, 20);
        #2 rst_n = 1'b0;
        s_tvalid = 1'b0;
        #1;
        check("midrst_tvalid", 32'(m_tvalid), 32'd0);
        check("midrst_s_tready", 32'(s_tready), 32'd1);
        check("midrst_line_num", 32'(line_num), 32'd0);
        check("midrst_flags", {30'd0, m_tuser, m_tlast}, 32'd0);
        exp_q.delete();
        exp_line = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_packet(0, 1'b0, 1'b0, 40);
        drain_and_check("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
